// File: rtl/upower_store_datapath.sv
// -----------------------------------------------------------------------------
// upower_store_datapath
//   Bring-up datapath for uPower D-form word stores (stw RS, D(RA)).
//   A 32-entry register file supplies the base RA and the store source RS,
//   the ALU adds RA to the sign-extended displacement to form a word address,
//   and RS is written into the word-addressed data memory at that address.
//
// Ports
//   clk          rising-edge clock for register file and memory updates
//   rst          asynchronous active-low reset (0 = reset)
//   instruction  [25:21] RS, [20:16] RA, [15:0] signed displacement D
//   alu_op       ALU function select
//   reg_write    register file write enable
//   wr_addr      register file write index
//   wr_data      register file write data
//   mem_read     gates the memory word onto read_data
//   mem_write    data memory write enable
//   alu_result   ALU result, used as the effective word address
//   cout         ALU carry out (ADD / SUB / SLT only)
//   slt          signed R[RA] < imm, independent of alu_op
//   overflow     signed overflow (ADD / SUB only)
//   zero         alu_result == 0
//   store_data   R[RS], the word presented to memory
//   read_data    memory word at alu_result when mem_read, else 0
// -----------------------------------------------------------------------------
module upower_store_datapath #(
  parameter int N         = 32,
  parameter int MEM_DEPTH = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  instruction,
  input  logic [3:0]   alu_op,
  input  logic         reg_write,
  input  logic [4:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic         mem_read,
  input  logic         mem_write,
  output logic [N-1:0] alu_result,
  output logic         cout,
  output logic         slt,
  output logic         overflow,
  output logic         zero,
  output logic [N-1:0] store_data,
  output logic [N-1:0] read_data
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  // Sign-extend the 16-bit displacement to the datapath width.
  function automatic logic [N-1:0] sign_ext_d(input logic [15:0] d);
    return {{(N-16){d[15]}}, d};
  endfunction

  logic [N-1:0]  reg_file_r [32];
  logic [N-1:0]  mem_r [MEM_DEPTH];

  logic [4:0]    rs_idx_s;
  logic [4:0]    ra_idx_s;
  logic [N-1:0]  a_s;
  logic [N-1:0]  b_s;
  logic [N:0]    sum_s;
  logic [N:0]    diff_s;
  logic          add_ovf_s;
  logic          sub_ovf_s;
  logic          slt_s;
  logic [N-1:0]  result_s;
  logic          cout_s;
  logic          ovf_s;
  logic [AW-1:0] mem_idx_s;
  logic          unused_opcode_s;

  // The primary opcode is decoded upstream; this block only sees stores.
  assign unused_opcode_s = ^instruction[31:26];

  assign rs_idx_s = instruction[25:21];
  assign ra_idx_s = instruction[20:16];

  // Operand fetch: both register reads are combinational with no write bypass.
  always_comb begin
    a_s        = reg_file_r[ra_idx_s];
    b_s        = sign_ext_d(instruction[15:0]);
    store_data = reg_file_r[rs_idx_s];
  end

  // ALU: shared adder/subtractor, function select, carry and overflow.
  always_comb begin
    sum_s     = {1'b0, a_s} + {1'b0, b_s};
    diff_s    = {1'b0, a_s} + {1'b0, ~b_s} + {{N{1'b0}}, 1'b1};
    add_ovf_s = (a_s[N-1] == b_s[N-1]) && (sum_s[N-1] != a_s[N-1]);
    sub_ovf_s = (a_s[N-1] != b_s[N-1]) && (diff_s[N-1] != a_s[N-1]);
    // Signed less-than: sign of the difference corrected by overflow.
    slt_s     = diff_s[N-1] ^ sub_ovf_s;
    result_s  = {N{1'b0}};
    cout_s    = 1'b0;
    ovf_s     = 1'b0;
    case (alu_op)
      OP_AND: result_s = a_s & b_s;
      OP_OR:  result_s = a_s | b_s;
      OP_ADD: begin
        result_s = sum_s[N-1:0];
        cout_s   = sum_s[N];
        ovf_s    = add_ovf_s;
      end
      OP_SUB: begin
        result_s = diff_s[N-1:0];
        cout_s   = diff_s[N];
        ovf_s    = sub_ovf_s;
      end
      OP_SLT: begin
        result_s = {{(N-1){1'b0}}, slt_s};
        cout_s   = diff_s[N];
      end
      OP_NOR: result_s = ~(a_s | b_s);
      default: begin
        result_s = {N{1'b0}};
        cout_s   = 1'b0;
        ovf_s    = 1'b0;
      end
    endcase
  end

  // Drive ALU outputs and flags.
  always_comb begin
    alu_result = result_s;
    cout       = cout_s;
    overflow   = ovf_s;
    slt        = slt_s;
    zero       = (result_s == {N{1'b0}});
  end

  // Word index: upper address bits are ignored so addresses alias modulo depth.
  assign mem_idx_s = result_s[AW-1:0];

  // Combinational memory read port, gated by mem_read.
  always_comb begin
    if (mem_read) begin
      read_data = mem_r[mem_idx_s];
    end else begin
      read_data = {N{1'b0}};
    end
  end

  // Register file: reset loads R[i] = i, otherwise one write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        reg_file_r[i] <= N'(i);
      end
    end else if (reg_write) begin
      reg_file_r[wr_addr] <= wr_data;
    end
  end

  // Data memory: reset clears every word; a store takes the pre-edge R[RS].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_r[i] <= {N{1'b0}};
      end
    end else if (mem_write) begin
      mem_r[mem_idx_s] <= store_data;
    end
  end

endmodule

// File: tb/tb_upower_store_datapath.sv
// -----------------------------------------------------------------------------
// tb_upower_store_datapath
//   Directed bench for the uPower store datapath. Each step drives inputs,
//   pushes the reference model's expected outputs onto a scoreboard queue,
//   and pops/compares them at the following falling edge. Key results are
//   additionally checked against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_upower_store_datapath;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        c;
    logic        s;
    logic        o;
    logic        z;
    logic [31:0] sd;
    logic [31:0] rd;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [3:0]  alu_op;
  logic        reg_write;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] alu_result;
  logic        cout;
  logic        slt;
  logic        overflow;
  logic        zero;
  logic [31:0] store_data;
  logic [31:0] read_data;

  logic [31:0] m_reg [32];
  logic [31:0] m_mem [128];
  exp_t        sb_q [$];
  int          n_assert;
  int          n_fail;

  upower_store_datapath #(.N(32), .MEM_DEPTH(128)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .alu_op      (alu_op),
    .reg_write   (reg_write),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .alu_result  (alu_result),
    .cout        (cout),
    .slt         (slt),
    .overflow    (overflow),
    .zero        (zero),
    .store_data  (store_data),
    .read_data   (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input int rs, input int ra, input logic [15:0] d);
    logic [4:0] rs5;
    logic [4:0] ra5;
    rs5 = 5'(rs);
    ra5 = 5'(ra);
    return {6'd36, rs5, ra5, d};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'(i);
    for (int i = 0; i < 128; i++) m_mem[i] = 32'd0;
  endtask

  // Reference outputs for the currently driven inputs and model state.
  function automatic exp_t model(input string tag);
    exp_t        e;
    logic [31:0] a;
    logic [31:0] b;
    longint      sa;
    longint      sb;
    longint      t;
    logic [63:0] u;
    a  = m_reg[instruction[20:16]];
    b  = {{16{instruction[15]}}, instruction[15:0]};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.tag = tag;
    e.res = 32'd0;
    e.c   = 1'b0;
    e.o   = 1'b0;
    case (alu_op)
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_NOR: e.res = ~(a | b);
      OP_ADD: begin
        u     = {32'd0, a} + {32'd0, b};
        e.res = u[31:0];
        e.c   = (u > 64'h0000_0000_FFFF_FFFF);
        t     = sa + sb;
        e.o   = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      OP_SUB: begin
        e.res = a - b;
        e.c   = (a >= b);
        t     = sa - sb;
        e.o   = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      OP_SLT: begin
        e.res = (sa < sb) ? 32'd1 : 32'd0;
        e.c   = (a >= b);
      end
      default: e.res = 32'd0;
    endcase
    e.s  = (sa < sb);
    e.z  = (e.res == 32'd0);
    e.sd = m_reg[instruction[25:21]];
    e.rd = mem_read ? m_mem[e.res[6:0]] : 32'd0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] ins, input logic [3:0] op,
                        input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                        input logic mr, input logic mw);
    instruction = ins;
    alu_op      = op;
    reg_write   = rw;
    wr_addr     = wa;
    wr_data     = wd;
    mem_read    = mr;
    mem_write   = mw;
  endtask

  // Pop the oldest expectation and compare every output against it.
  task automatic compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, ".res"}, alu_result, e.res);
      chk({e.tag, ".cout"}, {31'd0, cout}, {31'd0, e.c});
      chk({e.tag, ".slt"}, {31'd0, slt}, {31'd0, e.s});
      chk({e.tag, ".ovf"}, {31'd0, overflow}, {31'd0, e.o});
      chk({e.tag, ".zero"}, {31'd0, zero}, {31'd0, e.z});
      chk({e.tag, ".sd"}, store_data, e.sd);
      chk({e.tag, ".rd"}, read_data, e.rd);
    end
  endtask

  task automatic drive(input string tag, input logic [31:0] ins, input logic [3:0] op,
                       input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mr, input logic mw);
    set_in(ins, op, rw, wa, wd, mr, mw);
    sb_q.push_back(model(tag));
    @(negedge clk);
    compare();
  endtask

  // Apply the coming edge to the model, then move just past that edge.
  task automatic tick();
    exp_t e;
    e = model("");
    if (rst) begin
      if (mem_write) m_mem[e.res[6:0]] = m_reg[instruction[25:21]];
      if (reg_write) m_reg[wr_addr] = wr_data;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b0;
    set_in(32'd0, OP_ADD, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    model_reset();
    @(posedge clk);
    #1;

    // Under reset: writes must be ignored and outputs follow reset state.
    drive("in_rst", mk_instr(7, 3, 16'd2), OP_ADD, 1'b1, 5'd7, 32'hFFFF_0000, 1'b1, 1'b1);
    chk("in_rst.sd_const", store_data, 32'd7);
    tick();
    rst = 1'b1;

    // Reset contents: R[k] = k, memory all zero.
    for (int k = 0; k < 32; k++) begin
      drive($sformatf("rst_r%0d", k), mk_instr(k, 0, 16'(k * 4)), OP_ADD,
            1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      tick();
    end

    // stw R1,2(R4)
    drive("stw1", 32'h9024_0002, OP_ADD, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("stw1.addr_const", alu_result, 32'd6);
    chk("stw1.sd_const", store_data, 32'd1);
    tick();
    drive("stw1_rd", 32'h9024_0002, OP_ADD, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("stw1_rd.const", read_data, 32'd1);
    tick();

    // stw R5,2(R2)
    drive("stw2", 32'h90A2_0002, OP_ADD, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("stw2.addr_const", alu_result, 32'd4);
    tick();
    drive("stw2_rd", 32'h90A2_0002, OP_ADD, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("stw2_rd.const", read_data, 32'd5);
    tick();
    drive("stw1_keep", 32'h9024_0002, OP_ADD, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("stw1_keep.const", read_data, 32'd1);
    tick();

    // Negative displacement: 4 + (-2)
    drive("negd", mk_instr(0, 4, 16'hFFFE), OP_ADD, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("negd.res_const", alu_result, 32'd2);
    chk("negd.cout_const", {31'd0, cout}, 32'd1);
    chk("negd.ovf_const", {31'd0, overflow}, 32'd0);
    tick();

    // Load sweep operands: R10 = 0x7FFFFFFF, R11 = -1, R12 = 0x80000000
    drive("wr10", mk_instr(10, 0, 16'd0), OP_AND, 1'b1, 5'd10, 32'h7FFF_FFFF, 1'b0, 1'b0);
    chk("wr10.nobypass", store_data, 32'd10);
    tick();
    drive("wr11", mk_instr(0, 0, 16'd0), OP_AND, 1'b1, 5'd11, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();
    drive("wr12", mk_instr(0, 0, 16'd0), OP_AND, 1'b1, 5'd12, 32'h8000_0000, 1'b0, 1'b0);
    tick();

    drive("add_ovf", mk_instr(0, 10, 16'd1), OP_ADD, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("add_ovf.res_const", alu_result, 32'h8000_0000);
    chk("add_ovf.ovf_const", {31'd0, overflow}, 32'd1);
    tick();
    drive("sub_eq", mk_instr(0, 3, 16'd3), OP_SUB, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("sub_eq.zero_const", {31'd0, zero}, 32'd1);
    tick();
    drive("slt_neg", mk_instr(0, 11, 16'd1), OP_SLT, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("slt_neg.res_const", alu_result, 32'd1);
    tick();
    drive("sub_ovf", mk_instr(0, 12, 16'd1), OP_SUB, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("sub_ovf.res_const", alu_result, 32'h7FFF_FFFF);
    chk("sub_ovf.ovf_const", {31'd0, overflow}, 32'd1);
    tick();
    drive("slt_ovf", mk_instr(0, 12, 16'd1), OP_SLT, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    drive("and", mk_instr(0, 10, 16'h00F0), OP_AND, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    drive("or", mk_instr(0, 12, 16'h8001), OP_OR, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    drive("nor", mk_instr(0, 10, 16'h1234), OP_NOR, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    drive("undef", mk_instr(0, 11, 16'd1), 4'b1111, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("undef.res_const", alu_result, 32'd0);
    tick();
    drive("undef3", mk_instr(0, 10, 16'd1), 4'b0011, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();

    // Same-edge register write and store: memory takes the old R1.
    drive("rw_mw", mk_instr(1, 0, 16'd32), OP_ADD, 1'b1, 5'd1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    tick();
    drive("rw_mw_rd", mk_instr(1, 0, 16'd32), OP_ADD, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("rw_mw_rd.const", read_data, 32'd1);
    chk("rw_mw_rd.newr1", store_data, 32'hDEAD_BEEF);
    tick();
    drive("st_new", mk_instr(1, 0, 16'd33), OP_ADD, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    drive("st_new_rd", mk_instr(0, 0, 16'd33), OP_ADD, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("st_new_rd.const", read_data, 32'hDEAD_BEEF);
    tick();

    // Address aliasing: 160 maps to word 32.
    drive("alias", mk_instr(0, 0, 16'd160), OP_ADD, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("alias.const", read_data, 32'd1);
    tick();

    // Read and write together: old word before the edge, new word after.
    drive("rdwr", mk_instr(5, 0, 16'd40), OP_ADD, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    chk("rdwr.old_const", read_data, 32'd0);
    tick();
    drive("rdwr_after", mk_instr(5, 0, 16'd40), OP_ADD, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("rdwr_after.const", read_data, 32'd5);
    tick();

    // Reset mid-cycle with writes pending: both writes must be dropped.
    set_in(mk_instr(5, 4, 16'd2), OP_ADD, 1'b1, 5'd5, 32'h1234_5678, 1'b1, 1'b1);
    #2;
    rst = 1'b0;
    model_reset();
    sb_q.push_back(model("midrst"));
    @(negedge clk);
    compare();
    chk("midrst.rd_const", read_data, 32'd0);
    tick();
    rst = 1'b1;
    drive("post_rst_r1", mk_instr(1, 4, 16'd2), OP_ADD, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("post_rst_r1.const", store_data, 32'd1);
    chk("post_rst_m6.const", read_data, 32'd0);
    tick();
    drive("post_rst_r5", mk_instr(5, 0, 16'd40), OP_ADD, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("post_rst_r5.const", store_data, 32'd5);
    tick();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
